// File: rtl/riscv_configs.sv
`default_nettype none
// ============================================================================
// Package : riscv_configs
// Shared register-file constants and address helpers for the integer core.
// Rev     : 1.0
// ============================================================================
package riscv_configs;

  localparam int c_XLEN       = 32;
  localparam int c_REG_ADDR_W = 5;
  localparam int c_NREG_RV32I = 32;
  localparam int c_NREG_RV32E = 16;
  localparam int c_X0         = 0;

  typedef logic [c_REG_ADDR_W-1:0] reg_addr_t;

  function automatic logic addr_in_range(input reg_addr_t addr, input int nreg);
    return (int'(addr) < nreg);
  endfunction

  // A register that can actually hold state: in range and not the hardwired zero.
  function automatic logic addr_is_target(input reg_addr_t addr, input int nreg);
    return addr_in_range(addr, nreg) && (addr != reg_addr_t'(c_X0));
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Interface : riscv_regfile_mp_if
// Decode/writeback-side bus of the multi-port register file.
// Rev       : 1.0
// ============================================================================
interface riscv_regfile_mp_if
  import riscv_configs::*;
#(
  parameter int XLEN = c_XLEN,
  parameter int NRD  = 2,
  parameter int NWR  = 1
);

  logic [NRD*c_REG_ADDR_W-1:0] i_rd_addr;
  logic [NRD*XLEN-1:0]         o_rd_data;
  logic [NRD-1:0]              o_rd_busy;
  logic [NWR-1:0]              i_wr_en;
  logic [NWR*c_REG_ADDR_W-1:0] i_wr_addr;
  logic [NWR*XLEN-1:0]         i_wr_data;
  logic                        i_alloc_en;
  reg_addr_t                   i_alloc_addr;
  logic                        i_flush;
  logic                        o_addr_err;

  modport master (
    output i_rd_addr, i_wr_en, i_wr_addr, i_wr_data, i_alloc_en, i_alloc_addr, i_flush,
    input  o_rd_data, o_rd_busy, o_addr_err
  );

  modport slave (
    input  i_rd_addr, i_wr_en, i_wr_addr, i_wr_data, i_alloc_en, i_alloc_addr, i_flush,
    output o_rd_data, o_rd_busy, o_addr_err
  );

endinterface
`default_nettype wire

// File: rtl/riscv_regfile_rdport.sv
`default_nettype none
// ============================================================================
// Module : riscv_regfile_rdport
// One read port: range check, x0 masking, write bypass, optional output flop.
// Rev    : 1.0
// ============================================================================
module riscv_regfile_rdport
  import riscv_configs::*;
#(
  parameter int XLEN   = c_XLEN,
  parameter int NREG   = c_NREG_RV32I,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  parameter int RD_LAT = 0
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  reg_addr_t                   i_addr,
  input  logic [NREG*XLEN-1:0]        i_regs,
  input  logic [NREG-1:0]             i_pending,
  input  logic [NWR-1:0]              i_wr_en,
  input  logic [NWR*c_REG_ADDR_W-1:0] i_wr_addr,
  input  logic [NWR*XLEN-1:0]         i_wr_data,
  input  logic                        i_alloc_en,
  input  reg_addr_t                   i_alloc_addr,
  output logic [XLEN-1:0]             o_data,
  output logic                        o_busy
);

  localparam int IDX_W = $clog2(NREG);

  logic [IDX_W-1:0] w_idx;
  logic             w_hit;
  logic             w_alloc_hit;
  logic [XLEN-1:0]  w_fwd_data;
  logic [XLEN-1:0]  w_data;
  logic             w_busy;
  logic [XLEN-1:0]  r_data;
  logic             r_busy;

  assign w_idx       = i_addr[IDX_W-1:0];
  assign w_alloc_hit = i_alloc_en && (i_alloc_addr == i_addr);

  // Scan ascending so the highest-index matching write port wins.
  always_comb begin
    w_hit      = 1'b0;
    w_fwd_data = '0;
    for (int j = 0; j < NWR; j++) begin
      if (i_wr_en[j] && (i_wr_addr[j*c_REG_ADDR_W +: c_REG_ADDR_W] == i_addr)) begin
        w_hit      = 1'b1;
        w_fwd_data = i_wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    w_data = i_regs[int'(w_idx)*XLEN +: XLEN];
    w_busy = i_pending[w_idx];
    if ((BYPASS != 0) && w_hit) begin
      w_data = w_fwd_data;
      if (!w_alloc_hit) begin
        w_busy = 1'b0;
      end
    end
    if (!addr_is_target(i_addr, NREG)) begin
      w_data = '0;
      w_busy = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= '0;
      r_busy <= 1'b0;
    end else begin
      r_data <= w_data;
      r_busy <= w_busy;
    end
  end

  assign o_data = (RD_LAT != 0) ? r_data : w_data;
  assign o_busy = (RD_LAT != 0) ? r_busy : w_busy;

endmodule
`default_nettype wire

// File: rtl/riscv_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module : riscv_regfile_mp
// Multi-port integer register file with pending-write scoreboard (RV32I/E).
// Rev    : 1.0
// ============================================================================
module riscv_regfile_mp
  import riscv_configs::*;
#(
  parameter int XLEN   = c_XLEN,
  parameter int NREG   = c_NREG_RV32I,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  parameter int RD_LAT = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  riscv_regfile_mp_if.slave  bus
);

  localparam int IDX_W = $clog2(NREG);

  if ((NREG != c_NREG_RV32I) && (NREG != c_NREG_RV32E)) begin : g_chk_nreg
    $error("riscv_regfile_mp: NREG must be 32 or 16");
  end
  if ((NRD < 1) || (NRD > 4)) begin : g_chk_nrd
    $error("riscv_regfile_mp: NRD must be 1..4");
  end
  if ((NWR < 1) || (NWR > 2)) begin : g_chk_nwr
    $error("riscv_regfile_mp: NWR must be 1..2");
  end
  if ((BYPASS != 0) && (BYPASS != 1)) begin : g_chk_bypass
    $error("riscv_regfile_mp: BYPASS must be 0 or 1");
  end
  if ((RD_LAT != 0) && (RD_LAT != 1)) begin : g_chk_rd_lat
    $error("riscv_regfile_mp: RD_LAT must be 0 or 1");
  end
  if (XLEN < 1) begin : g_chk_xlen
    $error("riscv_regfile_mp: XLEN must be positive");
  end

  logic [XLEN-1:0]      r_regs [NREG];
  logic [NREG-1:0]      r_pending;
  logic                 r_addr_err;
  logic [NREG-1:0]      w_pending_nxt;
  logic                 w_addr_err;
  logic [NWR-1:0]       w_wr_ok;
  logic [IDX_W-1:0]     w_wr_idx [NWR];
  logic                 w_alloc_ok;
  logic [IDX_W-1:0]     w_alloc_idx;
  logic [NREG*XLEN-1:0] w_regs_flat;

  assign w_alloc_ok  = bus.i_alloc_en && addr_is_target(bus.i_alloc_addr, NREG);
  assign w_alloc_idx = bus.i_alloc_addr[IDX_W-1:0];

  always_comb begin
    w_addr_err = bus.i_alloc_en && !addr_in_range(bus.i_alloc_addr, NREG);
    for (int j = 0; j < NWR; j++) begin
      w_wr_ok[j]  = bus.i_wr_en[j] &&
                    addr_is_target(bus.i_wr_addr[j*c_REG_ADDR_W +: c_REG_ADDR_W], NREG);
      w_wr_idx[j] = bus.i_wr_addr[j*c_REG_ADDR_W +: IDX_W];
      if (bus.i_wr_en[j] && !addr_in_range(bus.i_wr_addr[j*c_REG_ADDR_W +: c_REG_ADDR_W], NREG)) begin
        w_addr_err = 1'b1;
      end
    end
  end

  // Later assignments win: flush over alloc over write-clear. An alloc that
  // coincides with a write stays pending since the write retires an older producer.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int j = 0; j < NWR; j++) begin
      if (w_wr_ok[j]) begin
        w_pending_nxt[w_wr_idx[j]] = 1'b0;
      end
    end
    if (w_alloc_ok) begin
      w_pending_nxt[w_alloc_idx] = 1'b1;
    end
    if (bus.i_flush) begin
      w_pending_nxt = '0;
    end
    w_pending_nxt[c_X0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_pending  <= '0;
      r_addr_err <= 1'b0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (w_wr_ok[j]) begin
          r_regs[w_wr_idx[j]] <= bus.i_wr_data[j*XLEN +: XLEN];
        end
      end
      r_pending  <= w_pending_nxt;
      r_addr_err <= w_addr_err;
    end
  end

  always_comb begin
    w_regs_flat = '0;
    for (int i = 1; i < NREG; i++) begin
      w_regs_flat[i*XLEN +: XLEN] = r_regs[i];
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rdport
    riscv_regfile_rdport #(
      .XLEN   (XLEN),
      .NREG   (NREG),
      .NWR    (NWR),
      .BYPASS (BYPASS),
      .RD_LAT (RD_LAT)
    ) u_rdport (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_addr       (bus.i_rd_addr[k*c_REG_ADDR_W +: c_REG_ADDR_W]),
      .i_regs       (w_regs_flat),
      .i_pending    (r_pending),
      .i_wr_en      (bus.i_wr_en),
      .i_wr_addr    (bus.i_wr_addr),
      .i_wr_data    (bus.i_wr_data),
      .i_alloc_en   (bus.i_alloc_en),
      .i_alloc_addr (bus.i_alloc_addr),
      .o_data       (bus.o_rd_data[k*XLEN +: XLEN]),
      .o_busy       (bus.o_rd_busy[k])
    );
  end

  assign bus.o_addr_err = r_addr_err;

endmodule
`default_nettype wire
